btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_cond_pkg.sv | 22 ++
 rtl/btn_cond_ch.sv | 134 +++++++++++++
 rtl/btn_conditioner.sv | 36 +++
 tb/tb_btn_conditioner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and default timing constants for the button conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } btn_state_e;

  localparam int unsigned DefDebounceCycles = 32'd1000000;   // 10 ms at 100 MHz
  localparam int unsigned DefRepeatDelay    = 32'd50000000;  // 500 ms
  localparam int unsigned DefRepeatPeriod   = 32'd10000000;  // 100 ms

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and optional auto-repeat.
// Auto-repeat is built only when BTN_COND_REPEAT_EN is defined.
module btn_cond_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic repeat_pulse_o
);

  localparam int unsigned MaxCycles = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, s_q;
  btn_state_e state_q;
  logic [CntW-1:0] cnt_q, cnt_inc;
  logic cnt_done;
  logic pressed_q, press_q, release_q;

  // Reset value 0 means "released" after the inversion.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= ~btn_n_i;
      s_q     <= sync1_q;
    end
  end

  assign cnt_inc  = cnt_q + CntW'(1);
  assign cnt_done = (cnt_inc == DbLast);

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s_q) begin
            state_q <= StPressWait;
            cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (!s_q) begin
            state_q <= StIdle;
          end else if (cnt_done) begin
            state_q   <= StHeld;
            pressed_q <= 1'b1;
            press_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StHeld: begin
          if (!s_q) begin
            state_q <= StReleaseWait;
            cnt_q   <= '0;
          end
        end
        StReleaseWait: begin
          if (s_q) begin
            state_q <= StHeld;
          end else if (cnt_done) begin
            state_q   <= StIdle;
            pressed_q <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

`ifdef BTN_COND_REPEAT_EN
  localparam logic [CntW-1:0] RdLast = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] RpLast = CntW'(REPEAT_PERIOD);

  logic [CntW-1:0] rcnt_q, rcnt_inc;
  logic rfirst_q, repeat_q;

  assign rcnt_inc = rcnt_q + CntW'(1);

  // Count only while settled in HELD, so a release bounce pauses rather than restarts.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rcnt_q   <= '0;
      rfirst_q <= 1'b1;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (state_q == StPressWait && s_q && cnt_done) begin
        rcnt_q   <= '0;
        rfirst_q <= 1'b1;
      end else if (state_q == StHeld && s_q) begin
        if (rcnt_inc == (rfirst_q ? RdLast : RpLast)) begin
          rcnt_q   <= '0;
          rfirst_q <= 1'b0;
          repeat_q <= 1'b1;
        end else begin
          rcnt_q <= rcnt_inc;
        end
      end
    end
  end

  assign repeat_pulse_o = repeat_q;
`else
  assign repeat_pulse_o = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one independent btn_cond_ch per button.
// Optional auto-repeat enabled by BTN_COND_REPEAT_EN.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic             clk100_i,
  input  logic             rstn_i,
  input  logic [N_BTN-1:0] btn_n_i,
  output logic [N_BTN-1:0] pressed_o,
  output logic [N_BTN-1:0] press_pulse_o,
  output logic [N_BTN-1:0] release_pulse_o,
  output logic [N_BTN-1:0] repeat_pulse_o
);

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_cond_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk100_i       (clk100_i),
      .rstn_i         (rstn_i),
      .btn_n_i        (btn_n_i[i]),
      .pressed_o      (pressed_o[i]),
      .press_pulse_o  (press_pulse_o[i]),
      .release_pulse_o(release_pulse_o[i]),
      .repeat_pulse_o (repeat_pulse_o[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;

  logic       clk100 = 1'b0;
  logic       rstn;
  logic [2:0] btn_n;
  logic [2:0] pressed, press_p, release_p, repeat_p;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BTN_COND_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  btn_conditioner #(
    .N_BTN          (3),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (40),
    .REPEAT_PERIOD  (10)
  ) dut (
    .clk100_i       (clk100),
    .rstn_i         (rstn),
    .btn_n_i        (btn_n),
    .pressed_o      (pressed),
    .press_pulse_o  (press_p),
    .release_pulse_o(release_p),
    .repeat_pulse_o (repeat_p)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    logic [2:0] btn_n;
    int         cycles;
    logic [2:0] pressed;
    logic [2:0] press;
    logic [2:0] rel;
  } vec_t;

  vec_t vecs[7];

  task automatic step(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".pressed"}, pressed, 3'b000);
    check({name, ".press"}, press_p, 3'b000);
    check({name, ".release"}, release_p, 3'b000);
    check({name, ".repeat"}, repeat_p, 3'b000);
  endtask

  initial begin
    // Channel 0: stable press, hold, stable release; pulse after edge 10 both ways.
    vecs[0] = '{3'b110, 9,  3'b000, 3'b000, 3'b000};
    vecs[1] = '{3'b110, 1,  3'b001, 3'b001, 3'b000};
    vecs[2] = '{3'b110, 1,  3'b001, 3'b000, 3'b000};
    vecs[3] = '{3'b110, 20, 3'b001, 3'b000, 3'b000};
    vecs[4] = '{3'b111, 9,  3'b001, 3'b000, 3'b000};
    vecs[5] = '{3'b111, 1,  3'b000, 3'b000, 3'b001};
    vecs[6] = '{3'b111, 1,  3'b000, 3'b000, 3'b000};

    rstn  = 1'b0;
    btn_n = 3'b111;
    step(3);
    check_all_zero("reset");
    rstn = 1'b1;
    step(2);

    for (int i = 0; i < 7; i++) begin
      btn_n = vecs[i].btn_n;
      step(vecs[i].cycles);
      check($sformatf("vec%0d.pressed", i), pressed, vecs[i].pressed);
      check($sformatf("vec%0d.press", i), press_p, vecs[i].press);
      check($sformatf("vec%0d.release", i), release_p, vecs[i].rel);
      check($sformatf("vec%0d.repeat", i), repeat_p, 3'b000);
    end

    // Repeated 5-cycle low glitches on channel 1 must never be accepted.
    for (int g = 0; g < 4; g++) begin
      btn_n = 3'b101;
      for (int k = 0; k < 5; k++) begin
        step(1);
        check_all_zero($sformatf("glitch%0d_lo%0d", g, k));
      end
      btn_n = 3'b111;
      for (int k = 0; k < 3; k++) begin
        step(1);
        check_all_zero($sformatf("glitch%0d_hi%0d", g, k));
      end
    end
    step(5);
    check_all_zero("glitch_settle");

    // Held channel 0 released with a 3-cycle bounce, then stable high.
    btn_n = 3'b110;
    step(10);
    check("bounce.press", press_p, 3'b001);
    step(5);
    btn_n = 3'b111;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) btn_n = 3'b110;
      step(1);
      check($sformatf("bounce%0d.pressed", k), pressed, 3'b001);
      check($sformatf("bounce%0d.press", k), press_p, 3'b000);
      check($sformatf("bounce%0d.release", k), release_p, 3'b000);
    end
    btn_n = 3'b111;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      check($sformatf("rel%0d.pressed", k), pressed, (k < 10) ? 3'b001 : 3'b000);
      check($sformatf("rel%0d.press", k), press_p, 3'b000);
      check($sformatf("rel%0d.release", k), release_p, (k == 10) ? 3'b001 : 3'b000);
    end

    // Reset while HELD: outputs clear at once, no release; held button re-debounced.
    btn_n = 3'b110;
    step(10);
    check("rst_pre.pressed", pressed, 3'b001);
    rstn = 1'b0;
    #1;
    check_all_zero("rst_async");
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_all_zero($sformatf("rst_hold%0d", k));
    end
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check($sformatf("rst_post%0d.press", k), press_p, (k == 10) ? 3'b001 : 3'b000);
      check($sformatf("rst_post%0d.release", k), release_p, 3'b000);
    end

    // Hold 100 cycles after the press pulse; repeats at +40, +50 ... +100 when enabled.
    for (int k = 1; k <= 100; k++) begin
      step(1);
      check($sformatf("repeat+%0d", k), repeat_p,
            {2'b00, RepEn && (k >= 40) && (k % 10 == 0)});
    end

    // All three pressed on the same edge.
    btn_n = 3'b111;
    step(15);
    check("all_idle.pressed", pressed, 3'b000);
    btn_n = 3'b000;
    step(9);
    check("all.press_early", press_p, 3'b000);
    step(1);
    check("all.press", press_p, 3'b111);
    check("all.pressed", pressed, 3'b111);
    step(1);
    check("all.press_after", press_p, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
